// File: rtl/exc_pkg.sv
// Shared codes, status bit positions and FSM states for the
// MEM-stage exception arbiter.
package exc_pkg;

  localparam logic [31:0] EXC_NONE = 32'h0000_0000;
  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0009;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000b;
  localparam logic [31:0] EXC_TRAP = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET = 32'h0000_000d;

  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_IM_LO = 8;
  localparam int ST_IM_HI = 15;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/int_sync2.sv
// Two-flop synchroniser for W asynchronous lines, async reset.
// Ports: clk, reset, d (raw lines), q (synchronised lines).
module int_sync2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/exception_ctrl.sv
// MEM-stage exception arbiter: picks one event, drives cp0 code,
// faulting PC, delay-slot bit, pipeline flush and redirect PC.
// Ports: clk, reset, mem_* instruction flags, int_i, time_int_i,
// status_i, epc_i in; excepttype_o, exc_pc_o, exc_in_ds_o,
// int_pend_o, flush_o, new_pc_o, exc_count_o out.
module exception_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_valid_i,
  input  logic [31:0]      mem_pc_i,
  input  logic             mem_in_ds_i,
  input  logic             mem_syscall_i,
  input  logic             mem_ri_i,
  input  logic             mem_ov_i,
  input  logic             mem_trap_i,
  input  logic             mem_eret_i,
  input  logic [7:0]       int_i,
  input  logic             time_int_i,
  input  logic [31:0]      status_i,
  input  logic [31:0]      epc_i,
  output logic [31:0]      excepttype_o,
  output logic [31:0]      exc_pc_o,
  output logic             exc_in_ds_o,
  output logic [7:0]       int_pend_o,
  output logic             flush_o,
  output logic [31:0]      new_pc_o,
  output logic [CNT_W-1:0] exc_count_o
);

  localparam int FCW = $clog2(FLUSH_CYCLES) + 1;
  localparam logic [FCW-1:0] CNT_INIT = FCW'(FLUSH_CYCLES - 1);

  state_t           state, state_n;
  logic [FCW-1:0]   cnt, cnt_n;
  logic [31:0]      pc_q, pc_n;
  logic [CNT_W-1:0] exc_cnt, exc_cnt_n;
  logic [7:0]       sync_q;
  logic             int_req;
  logic [31:0]      code;
  logic [31:0]      tgt;
  logic             take;

  int_sync2 #(
    .W (8)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (int_i),
    .q     (sync_q)
  );

  // Timer shares line 7 with the external source.
  assign int_pend_o = reset ? 8'h00
                    : {sync_q[7] | time_int_i, sync_q[6:0]};

  assign int_req = status_i[ST_IE] & ~status_i[ST_EXL]
                 & |(int_pend_o & status_i[ST_IM_HI:ST_IM_LO]);

  always_comb begin
    code = EXC_NONE;
    priority case (1'b1)
      int_req:       code = EXC_INT;
      mem_ri_i:      code = EXC_RI;
      mem_syscall_i: code = EXC_SYS;
      mem_trap_i:    code = EXC_TRAP;
      mem_ov_i:      code = EXC_OV;
      mem_eret_i:    code = EXC_ERET;
      default:       code = EXC_NONE;
    endcase
  end

  assign take = ~reset & (state == IDLE) & mem_valid_i
              & (code != EXC_NONE);
  assign tgt  = (code == EXC_ERET) ? epc_i : EXC_VECTOR;

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    pc_n         = pc_q;
    exc_cnt_n    = exc_cnt;
    excepttype_o = EXC_NONE;
    exc_pc_o     = '0;
    exc_in_ds_o  = 1'b0;
    flush_o      = 1'b0;
    new_pc_o     = '0;
    unique case (state)
      IDLE: begin
        if (take) begin
          excepttype_o = code;
          exc_pc_o     = mem_pc_i;
          exc_in_ds_o  = mem_in_ds_i;
          flush_o      = 1'b1;
          new_pc_o     = tgt;
          state_n      = FLUSH;
          cnt_n        = CNT_INIT;
          pc_n         = tgt;
          if (exc_cnt != {CNT_W{1'b1}})
            exc_cnt_n = exc_cnt + 1'b1;
        end
      end
      FLUSH: begin
        flush_o  = 1'b1;
        new_pc_o = pc_q;
        if (cnt == '0)
          state_n = IDLE;
        else
          cnt_n = cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pc_q    <= '0;
      exc_cnt <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pc_q    <= pc_n;
      exc_cnt <= exc_cnt_n;
    end
  end

  assign exc_count_o = exc_cnt;

endmodule

// File: tb/tb_exception_ctrl.sv
// Bench for exception_ctrl: directed steps then random traffic,
// every cycle checked against a behavioural model.
module tb_exception_ctrl;

  localparam int FC  = 2;
  localparam int CW  = 2;
  localparam int CMX = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_valid_i, mem_in_ds_i;
  logic [31:0]   mem_pc_i;
  logic          mem_syscall_i, mem_ri_i, mem_ov_i;
  logic          mem_trap_i, mem_eret_i;
  logic [7:0]    int_i;
  logic          time_int_i;
  logic [31:0]   status_i, epc_i;
  logic [31:0]   excepttype_o, exc_pc_o, new_pc_o;
  logic          exc_in_ds_o, flush_o;
  logic [7:0]    int_pend_o;
  logic [CW-1:0] exc_count_o;

  exception_ctrl #(
    .EXC_VECTOR   (32'h0000_0020),
    .FLUSH_CYCLES (FC),
    .CNT_W        (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_valid_i   (mem_valid_i),
    .mem_pc_i      (mem_pc_i),
    .mem_in_ds_i   (mem_in_ds_i),
    .mem_syscall_i (mem_syscall_i),
    .mem_ri_i      (mem_ri_i),
    .mem_ov_i      (mem_ov_i),
    .mem_trap_i    (mem_trap_i),
    .mem_eret_i    (mem_eret_i),
    .int_i         (int_i),
    .time_int_i    (time_int_i),
    .status_i      (status_i),
    .epc_i         (epc_i),
    .excepttype_o  (excepttype_o),
    .exc_pc_o      (exc_pc_o),
    .exc_in_ds_o   (exc_in_ds_o),
    .int_pend_o    (int_pend_o),
    .flush_o       (flush_o),
    .new_pc_o      (new_pc_o),
    .exc_count_o   (exc_count_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: remaining flush cycles, held target, event count,
  // and the raw interrupt values seen at the last two edges.
  int          busy;
  logic [31:0] held;
  int          count;
  logic [7:0]  hist[$];

  logic [31:0] e_type, e_pc, e_new;
  logic        e_ds, e_flush, e_take;
  logic [7:0]  e_pend;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    busy  = 0;
    held  = 32'h0;
    count = 0;
    hist  = '{8'h00, 8'h00};
  endtask

  task automatic model_expect();
    logic ireq;
    e_type = 32'h0;
    e_pc   = 32'h0;
    e_ds   = 1'b0;
    e_flush = 1'b0;
    e_new  = 32'h0;
    e_take = 1'b0;
    e_pend = 8'h00;
    if (!reset) begin
      e_pend = hist[1];
      if (time_int_i) e_pend[7] = 1'b1;
      if (busy > 0) begin
        e_flush = 1'b1;
        e_new   = held;
      end else if (mem_valid_i) begin
        ireq = status_i[0] && !status_i[1]
            && ((e_pend & status_i[15:8]) != 8'h00);
        if (ireq)               e_type = 32'h1;
        else if (mem_ri_i)      e_type = 32'ha;
        else if (mem_syscall_i) e_type = 32'h9;
        else if (mem_trap_i)    e_type = 32'hc;
        else if (mem_ov_i)      e_type = 32'hb;
        else if (mem_eret_i)    e_type = 32'hd;
        if (e_type != 32'h0) begin
          e_take  = 1'b1;
          e_flush = 1'b1;
          e_pc    = mem_pc_i;
          e_ds    = mem_in_ds_i;
          e_new   = (e_type == 32'hd) ? epc_i : 32'h20;
        end
      end
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      model_reset();
    end else begin
      if (busy > 0) begin
        busy--;
      end else if (e_take) begin
        busy  = FC;
        held  = e_new;
        count = (count < CMX) ? count + 1 : CMX;
      end
      hist.push_front(int_i);
      void'(hist.pop_back());
    end
  endtask

  task automatic check_all();
    model_expect();
    chk("excepttype", excepttype_o, e_type);
    chk("exc_pc", exc_pc_o, e_pc);
    chk("exc_in_ds", 32'(exc_in_ds_o), 32'(e_ds));
    chk("int_pend", 32'(int_pend_o), 32'(e_pend));
    chk("flush", 32'(flush_o), 32'(e_flush));
    chk("new_pc", new_pc_o, e_new);
    chk("exc_count", 32'(exc_count_o), 32'(count));
  endtask

  // Entered at posedge+1; checks mid-cycle, returns at posedge+1.
  task automatic cycle();
    #4;
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_in();
    mem_valid_i   = 1'b0;
    mem_pc_i      = 32'h0;
    mem_in_ds_i   = 1'b0;
    mem_syscall_i = 1'b0;
    mem_ri_i      = 1'b0;
    mem_ov_i      = 1'b0;
    mem_trap_i    = 1'b0;
    mem_eret_i    = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    reset      = 1'b1;
    int_i      = 8'h00;
    time_int_i = 1'b0;
    status_i   = 32'h0;
    epc_i      = 32'h0;
    clear_in();
    model_reset();
    #1;
    idle(2);
    reset = 1'b0;
    idle(2);

    // Overflow in a delay slot.
    mem_valid_i = 1'b1; mem_ov_i = 1'b1;
    mem_pc_i = 32'h400; mem_in_ds_i = 1'b1;
    cycle();
    clear_in();
    idle(3);

    // External interrupt line 2, IM2 + IE.
    status_i = 32'h0000_0401;
    int_i = 8'h04;
    idle(3);
    mem_valid_i = 1'b1; mem_pc_i = 32'h500;
    cycle();
    clear_in();
    int_i = 8'h00;
    idle(4);

    // Same with EXL set: masked.
    status_i = 32'h0000_0403;
    int_i = 8'h04;
    idle(2);
    mem_valid_i = 1'b1; mem_pc_i = 32'h504;
    idle(3);
    clear_in();

    // ri + syscall + pending interrupt: interrupt wins.
    status_i = 32'h0000_0401;
    mem_valid_i = 1'b1; mem_pc_i = 32'h600;
    mem_ri_i = 1'b1; mem_syscall_i = 1'b1;
    cycle();
    clear_in();
    int_i = 8'h00;
    idle(4);

    // ri + syscall only.
    status_i = 32'h0;
    mem_valid_i = 1'b1; mem_pc_i = 32'h700;
    mem_ri_i = 1'b1; mem_syscall_i = 1'b1;
    cycle();
    clear_in();
    idle(3);

    // eret, with an overflow arriving during the flush.
    epc_i = 32'h1234;
    mem_valid_i = 1'b1; mem_pc_i = 32'h800; mem_eret_i = 1'b1;
    cycle();
    mem_eret_i = 1'b0; mem_ov_i = 1'b1; mem_pc_i = 32'h804;
    idle(2);
    clear_in();
    idle(1);

    // More events to push the counter against saturation.
    mem_valid_i = 1'b1; mem_trap_i = 1'b1; mem_pc_i = 32'h900;
    cycle();
    clear_in();
    idle(2);
    mem_valid_i = 1'b1; mem_syscall_i = 1'b1;
    cycle();
    clear_in();
    idle(2);

    // Bubble carrying an overflow flag: no take.
    mem_ov_i = 1'b1;
    idle(2);
    clear_in();

    // Reset during the first flush cycle.
    mem_valid_i = 1'b1; mem_ov_i = 1'b1; mem_pc_i = 32'ha00;
    cycle();
    clear_in();
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    cycle();
    reset = 1'b0;
    idle(2);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      mem_valid_i   = ($urandom_range(0, 3) != 0);
      mem_pc_i      = {$urandom_range(0, 65535), 16'h0} | 32'h4;
      mem_in_ds_i   = 1'($urandom_range(0, 1));
      mem_syscall_i = ($urandom_range(0, 7) == 0);
      mem_ri_i      = ($urandom_range(0, 7) == 0);
      mem_ov_i      = ($urandom_range(0, 7) == 0);
      mem_trap_i    = ($urandom_range(0, 7) == 0);
      mem_eret_i    = ($urandom_range(0, 7) == 0);
      time_int_i    = ($urandom_range(0, 7) == 0);
      epc_i         = $urandom;
      if ($urandom_range(0, 5) == 0)
        int_i = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) begin
        status_i = 32'h0;
        status_i[15:8] = 8'($urandom_range(0, 255));
        status_i[0] = 1'($urandom_range(0, 1));
        status_i[1] = ($urandom_range(0, 3) == 0);
      end
      if (reset) begin
        reset = 1'b0;
      end else if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1;
        model_reset();
      end
      cycle();
    end
    reset = 1'b0;
    clear_in();
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
